// File: rtl/jtag_tap_driver.sv
// rtl/jtag_tap_driver.sv - JTAG initiator: command stream in, TCK/TMS/TDI out, captured TDO bits back.
// Define JTAG_TRST_EN to add an active-low trst_n held low while a RESET command runs.
module jtag_tap_driver #(
  parameter int CLK_DIV = 2,
  parameter int MAX_LEN = 32,
  localparam int LW = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [LW-1:0]      cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               tck,
  output logic               tms,
  output logic               tdi,
  input  logic               tdo,
  output logic [3:0]         tap_state
`ifdef JTAG_TRST_EN
  ,output logic              trst_n
`endif
);
  localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [1:0] OP_RESET = 2'd0, OP_IR = 2'd1, OP_DR = 2'd2, OP_RUN = 2'd3;

  typedef enum logic [2:0] {ST_IDLE, ST_PRE, ST_SHIFT, ST_POST, ST_RUN, ST_RESP} st_e;

  st_e                st_q, st_d;
  logic [LW-1:0]      cnt_q, cnt_d, len_q, len_d, cnt_inc, len_sat;
  logic [1:0]         op_q, op_d;
  logic [MAX_LEN-1:0] data_q, data_d, rsp_q;
  logic [5:0]         pat_q, pat_d;
  logic [2:0]         pren_q, pren_d;
  logic [DW-1:0]      div_q;
  logic               tck_q, tms_q, tdi_q, tms_d, tdi_d;
  logic [3:0]         tap_q;
  logic               accept, load, busy, half_end, rise, done;

  function automatic logic [3:0] tap_next(input logic [3:0] s, input logic m);
    case (s)
      4'd0:  return m ? 4'd0  : 4'd1;
      4'd1:  return m ? 4'd2  : 4'd1;
      4'd2:  return m ? 4'd9  : 4'd3;
      4'd3:  return m ? 4'd5  : 4'd4;
      4'd4:  return m ? 4'd5  : 4'd4;
      4'd5:  return m ? 4'd8  : 4'd6;
      4'd6:  return m ? 4'd7  : 4'd6;
      4'd7:  return m ? 4'd8  : 4'd4;
      4'd8:  return m ? 4'd2  : 4'd1;
      4'd9:  return m ? 4'd0  : 4'd10;
      4'd10: return m ? 4'd12 : 4'd11;
      4'd11: return m ? 4'd12 : 4'd11;
      4'd12: return m ? 4'd15 : 4'd13;
      4'd13: return m ? 4'd14 : 4'd13;
      4'd14: return m ? 4'd15 : 4'd11;
      default: return m ? 4'd2 : 4'd1;
    endcase
  endfunction

  assign accept   = cmd_valid && cmd_ready;
  assign busy     = (st_q == ST_PRE) || (st_q == ST_SHIFT) || (st_q == ST_POST) || (st_q == ST_RUN);
  assign half_end = busy && (div_q == DW'(CLK_DIV - 1));
  assign rise     = half_end && !tck_q;
  assign done     = half_end && tck_q;

  always_ff @(posedge clk) begin
    if (rst) st_q <= ST_IDLE;
    else     st_q <= st_d;
  end

  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    op_d    = op_q;
    data_d  = data_q;
    pat_d   = pat_q;
    pren_d  = pren_q;
    load    = 1'b0;
    cnt_inc = cnt_q + 1'b1;
    len_sat = (cmd_len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : cmd_len;
    case (st_q)
      ST_IDLE: if (accept) begin
        load   = 1'b1;
        op_d   = cmd_op;
        len_d  = len_sat;
        data_d = cmd_data;
        cnt_d  = '0;
        // pat_d holds the TMS bits that lead into Shift (or straight to Exit1 when len is zero)
        case (cmd_op)
          OP_RESET: begin pat_d = 6'b011111; pren_d = 3'd6; end
          OP_IR:    begin pat_d = (len_sat == '0) ? 6'b001011 : 6'b000011; pren_d = 3'd4; end
          OP_DR:    begin pat_d = (len_sat == '0) ? 6'b000101 : 6'b000001; pren_d = 3'd3; end
          default:  begin pat_d = 6'b000000; pren_d = 3'd0; end
        endcase
        if (tap_q == 4'd0 && cmd_op != OP_RESET) begin
          pat_d  = {pat_d[4:0], 1'b0};
          pren_d = pren_d + 3'd1;
        end
        if (pren_d != 3'd0)      st_d = ST_PRE;
        else if (len_sat != '0)  st_d = ST_RUN;
        else                     st_d = ST_RESP;
      end
      ST_RESP: if (rsp_ready) st_d = ST_IDLE;
      default: if (done) begin
        load  = 1'b1;
        cnt_d = cnt_inc;
        case (st_q)
          ST_PRE: if (cnt_inc == LW'(pren_q)) begin
            cnt_d = '0;
            if (op_q == OP_RESET)  st_d = ST_RESP;
            else if (op_q == OP_RUN) st_d = (len_q != '0) ? ST_RUN : ST_RESP;
            else                   st_d = (len_q != '0) ? ST_SHIFT : ST_POST;
          end
          ST_SHIFT, ST_RUN: if (cnt_inc == len_q) begin
            cnt_d = '0;
            st_d  = (st_q == ST_SHIFT) ? ST_POST : ST_RESP;
          end
          ST_POST: if (cnt_q != '0) st_d = ST_RESP;
          default: ;
        endcase
      end
    endcase
    tms_d = tms_q;
    tdi_d = 1'b0;
    case (st_d)
      ST_PRE:   tms_d = pat_d[cnt_d[2:0]];
      ST_SHIFT: begin
        tms_d = (cnt_d == len_d - 1'b1);
        tdi_d = data_d[cnt_d[IW-1:0]];
      end
      ST_POST:  tms_d = (cnt_d == '0);
      ST_RUN:   tms_d = 1'b0;
      default:  ;
    endcase
  end

  always_comb begin
    cmd_ready = (st_q == ST_IDLE) && !rst;
    rsp_valid = (st_q == ST_RESP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0; len_q <= '0; op_q <= OP_RESET; data_q <= '0; pat_q <= '0; pren_q <= '0;
      div_q <= '0; tck_q <= 1'b0; tms_q <= 1'b1; tdi_q <= 1'b0; tap_q <= 4'd0; rsp_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      len_q  <= len_d;
      op_q   <= op_d;
      data_q <= data_d;
      pat_q  <= pat_d;
      pren_q <= pren_d;
      if (load) begin
        tck_q <= 1'b0;
        div_q <= '0;
        tms_q <= tms_d;
        tdi_q <= tdi_d;
      end else if (rise) begin
        tck_q <= 1'b1;
        div_q <= '0;
        tap_q <= tap_next(tap_q, tms_q);
        if (st_q == ST_SHIFT) rsp_q[cnt_q[IW-1:0]] <= tdo;
      end else if (busy) begin
        div_q <= div_q + 1'b1;
      end
      if (accept) rsp_q <= '0;
    end
  end

`ifdef JTAG_TRST_EN
  logic trst_q;
  always_ff @(posedge clk) begin
    if (rst)                              trst_q <= 1'b1;
    else if (accept && cmd_op == OP_RESET) trst_q <= 1'b0;
    else if (st_d == ST_RESP)             trst_q <= 1'b1;
  end
  assign trst_n = trst_q;
`endif

  assign tck       = tck_q;
  assign tms       = tms_q;
  assign tdi       = tdi_q;
  assign tap_state = tap_q;
  assign rsp_data  = rsp_q;
endmodule

// File: tb/tb_jtag_tap_driver.sv
// tb/tb_jtag_tap_driver.sv - scoreboard bench for jtag_tap_driver with a behavioural TAP on the pins.
module tb_jtag_tap_driver;
  localparam int CLK_DIV = 2;
  localparam int MAX_LEN = 32;
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam logic [31:0] IDCODE = 32'h12345679;

  logic clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0, rsp_ready = 1'b0, tdo = 1'b0;
  logic [1:0] cmd_op = 2'd0;
  logic [LW-1:0] cmd_len = '0;
  logic [31:0] cmd_data = 32'h0;
  logic cmd_ready, rsp_valid, tck, tms, tdi;
  logic [31:0] rsp_data;
  logic [3:0] tap_state;

  always #5 clk = ~clk;

  jtag_tap_driver #(.CLK_DIV(CLK_DIV), .MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_len(cmd_len), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo), .tap_state(tap_state)
  );

  int checks = 0, failures = 0;
  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endfunction

  // Pin-level TAP: 4-bit IR capturing 0101, IDCODE when IR=E, otherwise 1-bit bypass
  typedef enum int {TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PADR, EX2DR, UPDR,
                    SELIR, CAPIR, SHIR, EX1IR, PAIR, EX2IR, UPIR} tap_e;
  function automatic tap_e tap_step(input tap_e s, input logic m);
    case (s)
      TLR:   return m ? TLR : RTI;
      RTI, UPDR, UPIR: return m ? SELDR : RTI;
      SELDR: return m ? SELIR : CAPDR;
      CAPDR, SHDR: return m ? EX1DR : SHDR;
      EX1DR: return m ? UPDR : PADR;
      PADR:  return m ? EX2DR : PADR;
      EX2DR: return m ? UPDR : SHDR;
      SELIR: return m ? TLR : CAPIR;
      CAPIR, SHIR: return m ? EX1IR : SHIR;
      EX1IR: return m ? UPIR : PAIR;
      PAIR:  return m ? EX2IR : PAIR;
      default: return m ? UPIR : SHIR;
    endcase
  endfunction

  tap_e m_st = TLR;
  logic [3:0] m_ir = 4'hE, m_irsr = 4'h0;
  logic [31:0] m_drsr = 32'h0;
  logic tms_hist [4096];
  int n_rise = 0;

  always @(posedge tck) begin
    case (m_st)
      TLR:   m_ir = 4'hE;
      CAPIR: m_irsr = 4'b0101;
      SHIR:  m_irsr = {tdi, m_irsr[3:1]};
      UPIR:  m_ir = m_irsr;
      CAPDR: m_drsr = (m_ir == 4'hE) ? IDCODE : 32'h0;
      SHDR:  if (m_ir == 4'hE) m_drsr = {tdi, m_drsr[31:1]}; else m_drsr[0] = tdi;
      default: ;
    endcase
    m_st = tap_step(m_st, tms);
    tms_hist[n_rise % 4096] = tms;
    n_rise++;
  end
  always @(negedge tck) tdo = (m_st == SHIR) ? m_irsr[0] : (m_st == SHDR) ? m_drsr[0] : 1'b0;

  typedef struct { logic [31:0] rsp; int ntck; logic [63:0] tms; logic [3:0] ir; } exp_t;
  exp_t sb_q[$];
  logic ref_tlr = 1'b1;
  logic [3:0] ref_ir = 4'hE;

  task automatic drive_cmd(input logic [1:0] op, input int len, input logic [31:0] data);
    int t = 0;
    @(negedge clk);
    while (!cmd_ready && t < 3000) begin @(negedge clk); t++; end
    if (!cmd_ready) chk("cmd_ready_timeout", 64'(cmd_ready), 64'd1);
    cmd_op = op; cmd_len = LW'(len); cmd_data = data; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Expected TMS stream and captured bits from command-level rules
  task automatic issue(input logic [1:0] op, input int len_in, input logic [31:0] data);
    exp_t e;
    bit q[$];
    int L, w, t;
    logic [31:0] mask;
    logic [95:0] s, capv;
    L = (len_in > MAX_LEN) ? MAX_LEN : len_in;
    mask = (L >= 32) ? 32'hFFFF_FFFF : ((32'h1 << L) - 32'h1);
    e.rsp = 32'h0;
    if (ref_tlr && op != 2'd0) q.push_back(1'b0);
    case (op)
      2'd0: begin repeat (5) q.push_back(1'b1); q.push_back(1'b0); end
      2'd3: repeat (L) q.push_back(1'b0);
      default: begin
        q.push_back(1'b1);
        if (op == 2'd1) q.push_back(1'b1);
        q.push_back(1'b0);
        if (L == 0) q.push_back(1'b1);
        else begin
          q.push_back(1'b0);
          for (int i = 0; i < L; i++) q.push_back(i == L - 1);
        end
        q.push_back(1'b1);
        q.push_back(1'b0);
      end
    endcase
    if (op == 2'd1 || op == 2'd2) begin
      if (op == 2'd1)           begin w = 4;  capv = 96'h5; end
      else if (ref_ir == 4'hE)  begin w = 32; capv = {64'h0, IDCODE}; end
      else                      begin w = 1;  capv = 96'h0; end
      s = capv | ({64'h0, data & mask} << w);
      e.rsp = s[31:0] & mask;
      if (op == 2'd1) ref_ir = 4'(s >> L);
    end else if (op == 2'd0) ref_ir = 4'hE;
    e.ir = ref_ir;
    e.ntck = q.size();
    e.tms = 64'h0;
    for (int i = 0; i < q.size(); i++) e.tms[i] = q[i];
    ref_tlr = 1'b0;
    sb_q.push_back(e);
    drive_cmd(op, len_in, data);
    t = 0;
    while (sb_q.size() != 0 && t < 3000) begin @(negedge clk); t++; end
    chk("response_timeout", 64'(sb_q.size()), 64'd0);
  endtask

  int base = 0, hold = 0, nresp = 0;
  logic seen = 1'b0, stab_ok = 1'b1;
  logic [31:0] snap;

  always @(negedge clk) begin
    exp_t e;
    logic [63:0] act_tms;
    int n;
    if (rst) begin
      rsp_ready = 1'b0; seen = 1'b0; base = n_rise;
    end else if (!rsp_valid) begin
      rsp_ready = 1'b0;
    end else if (!rsp_ready) begin
      if (!seen) begin
        seen = 1'b1; snap = rsp_data; stab_ok = (tck == 1'b0) && !cmd_ready;
        hold = (nresp % 3 == 0) ? 10 : int'($urandom_range(0, 3));
        nresp++;
      end else if (rsp_data !== snap || tck !== 1'b0 || cmd_ready !== 1'b0) stab_ok = 1'b0;
      if (hold == 0) begin
        if (sb_q.size() == 0) chk("unexpected_response", 64'd1, 64'd0);
        else begin
          e = sb_q.pop_front();
          n = n_rise - base;
          act_tms = 64'h0;
          for (int i = 0; i < n && i < 64; i++) act_tms[i] = tms_hist[(base + i) % 4096];
          chk("rsp_data", 64'(rsp_data), 64'(e.rsp));
          chk("tck_count", 64'(n), 64'(e.ntck));
          chk("tms_seq", act_tms, e.tms);
          chk("tap_state_end", 64'(tap_state), 64'd1);
          chk("model_ir", 64'(m_ir), 64'(e.ir));
          chk("hold_stable", 64'(stab_ok), 64'd1);
        end
        base = n_rise;
        rsp_ready = 1'b1;
        seen = 1'b0;
      end else hold--;
    end else begin
      chk("rsp_valid_after_handshake", 64'd1, 64'd0);
      rsp_ready = 1'b0;
    end
  end

  initial begin
    int t;
    repeat (3) @(negedge clk);
    chk("rst_tck", 64'(tck), 64'd0);
    chk("rst_tms", 64'(tms), 64'd1);
    chk("rst_tdi", 64'(tdi), 64'd0);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_data", 64'(rsp_data), 64'd0);
    chk("rst_tap_state", 64'(tap_state), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 64'(cmd_ready), 64'd1);

    issue(2'd2, 32, $urandom);
    issue(2'd0, 0, 32'h0);
    issue(2'd1, 4, 32'hE);
    issue(2'd2, 32, $urandom);
    issue(2'd3, 0, 32'h0);
    issue(2'd2, 40, $urandom);
    issue(2'd3, 5, 32'h0);
    issue(2'd1, 0, 32'h0);
    issue(2'd2, 8, 32'hA5);

    drive_cmd(2'd2, 32, $urandom);
    t = 0;
    while (n_rise - base < 10 && t < 2000) begin @(negedge clk); t++; end
    chk("reach_bit10", 64'(n_rise - base >= 10), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_tck", 64'(tck), 64'd0);
    chk("mid_rst_tms", 64'(tms), 64'd1);
    chk("mid_rst_tap_state", 64'(tap_state), 64'd0);
    chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    ref_tlr = 1'b1;

    issue(2'd0, 0, 32'h0);
    for (int k = 0; k < 25; k++)
      issue(2'($urandom_range(0, 3)), int'($urandom_range(0, 40)), $urandom);

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/jtag_tap_driver.md
Name: jtag_tap_driver

Overview:
Host-side JTAG initiator that drives a TAP controller through its 16-state FSM from a system-clock command stream. It accepts RESET / SHIFT_IR / SHIFT_DR / RUN_IDLE commands, generates divided TCK with TMS/TDI, samples TDO, and returns the captured bits. It sits between on-chip or bench control logic and the TAP pins. It tracks the TAP state internally using the codebase TAP state encoding (0 = TEST_LOGIC_RESET … 15 = UPDATE_IR).

Parameters:
- CLK_DIV, 2, clk cycles per TCK half-period; minimum 1.
- MAX_LEN, 32, maximum shift length in bits; also the width of the data buses.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_op  in  2  0 = RESET, 1 = SHIFT_IR, 2 = SHIFT_DR, 3 = RUN_IDLE.
- cmd_len  in  $clog2(MAX_LEN+1)  bit count, or TCK count for RUN_IDLE.
- cmd_data  in  MAX_LEN  TDI bits, LSB shifted first.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumed.
- rsp_data  out  MAX_LEN  captured TDO bits, LSB first; bits at and above len are zero.
- tck  out  1  JTAG TCK.
- tms  out  1  JTAG TMS.
- tdi  out  1  JTAG TDI.
- tdo  in  1  JTAG TDO.
- tap_state  out  4  tracked TAP state (tap_ctrl_fsm_t encoding).

Behaviour:
- Reset values:
  - tck=0, tms=1, tdi=0.
  - cmd_ready=0; it goes to 1 on the first cycle after rst deasserts.
  - rsp_valid=0, rsp_data=0.
  - tap_state=0 (TEST_LOGIC_RESET).
- TCK bit timing: one TCK bit lasts 2*CLK_DIV clk cycles.
  - At bit start, tck falls and tms/tdi update on the same clk edge.
  - CLK_DIV cycles later, tck rises. tdo is registered on that edge, and tap_state advances per IEEE 1149.1 using the current tms.
  - When no command is active, tck is held at 0.
- FSM states: ST_IDLE, ST_PRE, ST_SHIFT, ST_POST, ST_RUN, ST_RESP.
  - ST_IDLE: cmd_ready=1. On accept, latch op/len/data; len above MAX_LEN saturates to MAX_LEN.
  - RESET: TMS 1,1,1,1,1,0 (6 TCK); ends in RUN_TEST_IDLE.
  - Leading TCK: if tap_state==TEST_LOGIC_RESET when a SHIFT or RUN_IDLE command is accepted, prepend one TMS=0 TCK to reach RUN_TEST_IDLE.
  - SHIFT_IR:
    - ST_PRE: TMS 1,1,0,0, reaching SHIFT_IR.
    - ST_SHIFT: len bits with TMS=0, except the last bit which has TMS=1 (to EXIT1_IR).
    - ST_POST: TMS 1,0 (UPDATE_IR, then RUN_TEST_IDLE).
    - Total: len+6 TCK.
  - SHIFT_DR: ST_PRE TMS 1,0,0, then the same shift and post sequence. Total: len+5 TCK.
  - len=0 on a shift: skip the SHIFT state.
    - Path: CAPTURE → EXIT1 (TMS=1) → UPDATE → RUN_TEST_IDLE.
    - rsp_data=0.
  - RUN_IDLE: len TCK with TMS=0 (ST_RUN). len=0 produces no TCK edge.
  - ST_RESP: every command produces exactly one response.
    - RESET and RUN_IDLE respond with rsp_data=0.
    - rsp_valid rises on the clk edge after the final TCK bit completes (tck back low).
    - rsp_valid and rsp_data are held stable until rsp_ready.
    - cmd_ready=0 throughout; return to ST_IDLE on the cycle rsp_valid && rsp_ready.
- Data ordering: tdi for bit i = cmd_data[i]; the tdo sampled on bit i → rsp_data[i].
- cmd_ready is 0 in every state except ST_IDLE. There are no simultaneous command/response overlaps.
- rst mid-operation:
  - Abandons the sequence and forces all reset values the next cycle.
  - Any pending response is dropped.
  - The physical TAP may now differ from tap_state; software issues RESET first.

Optional Feature:
- Macro JTAG_TRST_EN.
- Defined:
  - Adds output trst_n (1 bit, reset value 1).
  - RESET drives trst_n=0 from command accept until the final TCK bit completes, then 1. The TMS sequence is unchanged.
- Undefined: port absent; TAP reset is by TMS only.

Test Plan (CLK_DIV=2, MAX_LEN=32, behavioural TAP model on tck/tms/tdi/tdo):
- RESET cmd → 6 TCK, TMS 1,1,1,1,1,0, 24 clk of TCK activity; tap_state ends 1; rsp_data=0.
- SHIFT_IR len=4, data=4'hE, model IR capture 4'b0101 → TMS 1,1,0,0,0,0,0,1,1,0 (10 TCK); rsp_data=0x5; model IR=0xE (IDCODE).
- Then SHIFT_DR len=32 with model IDCODE 0x12345679 → 37 TCK; rsp_data=0x12345679; tap_state=1.
- rsp_ready=0 for 10 cycles after rsp_valid → rsp_valid/rsp_data stable, cmd_ready=0, tck=0 throughout.
- SHIFT_DR first after rst (no RESET) → one extra leading TMS=0 TCK. rst asserted at bit 10 of a shift → next cycle tck=0, tms=1, tap_state=0, rsp_valid=0.
- RUN_IDLE len=0 → rsp_valid without any tck edge. SHIFT_DR len=40 → clamped to 32 bits, 37 TCK.
